// File: rtl/conv_pkg.sv
// Shared defaults, pixel/coefficient types and reset coefficient bank for the
// conv_mac multiply-accumulate stage.
package conv_pkg;

  localparam int PIXEL_W_DEF = 8;
  localparam int TAPS_N_DEF  = 10;
  localparam int COEFF_W_DEF = 8;
  localparam int SHIFT_DEF   = 4;

  typedef logic [PIXEL_W_DEF-1:0]        pixel_t;
  typedef logic signed [COEFF_W_DEF-1:0] coeff_t;
  typedef coeff_t [TAPS_N_DEF-1:0]       coeff_bank_t;

  // Centre tap holds 1.0 in the coefficient's fixed-point format, so a freshly
  // reset block passes the middle pixel straight through.
  function automatic int reset_coeff(input int tap, input int taps, input int shift);
    return (tap == taps / 2) ? (1 << shift) : 0;
  endfunction

  function automatic coeff_bank_t reset_bank();
    coeff_bank_t bank;
    for (int k = 0; k < TAPS_N_DEF; k++) begin
      bank[k] = coeff_t'(reset_coeff(k, TAPS_N_DEF, SHIFT_DEF));
    end
    return bank;
  endfunction

endpackage

// File: rtl/conv_rnd_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of the accumulated
// sum into one unsigned output pixel.
module conv_rnd_sat #(
  parameter int ACC_W   = 21,
  parameter int SHIFT   = 4,
  parameter int PIXEL_W = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [PIXEL_W-1:0]      pixel
);

  localparam int RND_EXP = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int RND_I   = (SHIFT > 0) ? (1 << RND_EXP) : 0;
  localparam logic [ACC_W:0] RND = (ACC_W+1)'(RND_I);

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  // One guard bit keeps the rounding add from wrapping at the top of the range.
  always_comb begin
    rounded = {acc[ACC_W-1], acc} + RND;
    shifted = rounded >>> SHIFT;
    if (shifted[ACC_W]) begin
      pixel = '0;
    end else if (|shifted[ACC_W-1:PIXEL_W]) begin
      pixel = '1;
    end else begin
      pixel = shifted[PIXEL_W-1:0];
    end
  end

endmodule

// File: rtl/conv_mac.sv
// Three-stage pipelined MAC: per-tap products, sum, then round/shift/saturate,
// with a shadow/active coefficient bank swapped only at start of frame.
module conv_mac
  import conv_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int TAPS_N  = TAPS_N_DEF,
  parameter int COEFF_W = COEFF_W_DEF,
  parameter int SHIFT   = SHIFT_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_tvalid_i,
  input  logic [TAPS_N*PIXEL_W-1:0]     s_tdata_i,
  input  logic                          s_tuser_i,
  input  logic                          s_tlast_i,
  output logic                          s_tready_o,
  output logic                          m_tvalid_o,
  output logic [PIXEL_W-1:0]            m_tdata_o,
  output logic                          m_tuser_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(TAPS_N)-1:0]     cfg_addr_i,
  input  logic [COEFF_W-1:0]            cfg_data_i,
  input  logic                          cfg_commit_i,
  output logic                          cfg_pending_o
);

  localparam int PROD_W = PIXEL_W + COEFF_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(TAPS_N);

  logic signed [COEFF_W-1:0] shadow [TAPS_N];
  logic signed [COEFF_W-1:0] active [TAPS_N];
  logic                      pending;

  logic                      v1, v2, v3;
  logic                      user1, last1, user2, last2;
  logic signed [PROD_W-1:0]  prod1     [TAPS_N];
  logic signed [PROD_W-1:0]  prod_next [TAPS_N];
  logic signed [ACC_W-1:0]   acc2;
  logic signed [ACC_W-1:0]   acc_next;
  logic [PIXEL_W-1:0]        result;

  logic ld1, ld2, ld3;
  logic accept;
  logic swap;

  // Each stage may advance when it is empty or the stage after it advances,
  // so bubbles collapse and s_tready_o only drops when every stage is stalled.
  always_comb begin
    ld3    = !v3 || m_tready_i;
    ld2    = !v2 || ld3;
    ld1    = !v1 || ld2;
    accept = s_tvalid_i && ld1;
    swap   = accept && s_tuser_i && pending;
  end

  assign s_tready_o    = ld1;
  assign m_tvalid_o    = v3;
  assign cfg_pending_o = pending;

  // The start-of-frame beat that applies a commit already uses the new bank.
  always_comb begin
    logic signed [PROD_W-1:0]  pix_ext;
    logic signed [PROD_W-1:0]  coeff_ext;
    logic signed [COEFF_W-1:0] coeff;
    for (int k = 0; k < TAPS_N; k++) begin
      pix_ext       = {{(PROD_W-PIXEL_W){1'b0}}, s_tdata_i[k*PIXEL_W +: PIXEL_W]};
      coeff         = swap ? shadow[k] : active[k];
      coeff_ext     = {{(PROD_W-COEFF_W){coeff[COEFF_W-1]}}, coeff};
      prod_next[k]  = pix_ext * coeff_ext;
    end
  end

  always_comb begin
    acc_next = '0;
    for (int k = 0; k < TAPS_N; k++) begin
      acc_next = acc_next + {{(ACC_W-PROD_W){prod1[k][PROD_W-1]}}, prod1[k]};
    end
  end

  conv_rnd_sat #(
    .ACC_W   (ACC_W),
    .SHIFT   (SHIFT),
    .PIXEL_W (PIXEL_W)
  ) u_rnd_sat (
    .acc   (acc2),
    .pixel (result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      user1     <= 1'b0;
      last1     <= 1'b0;
      user2     <= 1'b0;
      last2     <= 1'b0;
      acc2      <= '0;
      m_tdata_o <= '0;
      m_tuser_o <= 1'b0;
      m_tlast_o <= 1'b0;
      for (int k = 0; k < TAPS_N; k++) begin
        prod1[k] <= '0;
      end
    end else begin
      if (ld1) begin
        v1 <= s_tvalid_i;
        if (s_tvalid_i) begin
          user1 <= s_tuser_i;
          last1 <= s_tlast_i;
          for (int k = 0; k < TAPS_N; k++) begin
            prod1[k] <= prod_next[k];
          end
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          acc2  <= acc_next;
          user2 <= user1;
          last2 <= last1;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          m_tdata_o <= result;
          m_tuser_o <= user2;
          m_tlast_o <= last2;
        end
      end
    end
  end

  // A commit that arrives while one is armed is absorbed; a write in the same
  // cycle as the commit lands in the shadow bank before any swap can happen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= 1'b0;
      for (int k = 0; k < TAPS_N; k++) begin
        shadow[k] <= COEFF_W'(reset_coeff(k, TAPS_N, SHIFT));
        active[k] <= COEFF_W'(reset_coeff(k, TAPS_N, SHIFT));
      end
    end else begin
      if (cfg_we_i && (int'(cfg_addr_i) < TAPS_N)) begin
        shadow[cfg_addr_i] <= cfg_data_i;
      end
      if (swap) begin
        pending <= 1'b0;
        for (int k = 0; k < TAPS_N; k++) begin
          active[k] <= shadow[k];
        end
      end else if (cfg_commit_i) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
